// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM state
// encoding, and the lane/byte-enable helpers used when issuing a bus request.
package lsu_pkg;

    localparam int XLEN            = 32;
    localparam int TIMEOUT_DEFAULT = 15;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_lane(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] data);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {24'b0, data[7:0]}  << {off, 3'b000};
            2'b01:   w = {16'b0, data[15:0]} << {off, 3'b000};
            default: w = data;
        endcase
        return w;
    endfunction

    // Rejected before any bus activity: bad alignment, reserved width codes,
    // and unsigned widths on stores.
    function automatic logic is_illegal(input logic [2:0] f3, input logic [1:0] off,
                                        input logic we);
        logic bad;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad | (we & f3[2]);
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side request/acknowledge bus of the load/store unit.
interface load_store_unit_if;
    import lsu_pkg::*;

    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [3:0]      bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_ack;
    logic [XLEN-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load-lane extraction: picks the addressed byte/half out of the
// read word and sign- or zero-extends it according to the width code.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        data = '0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = shifted;
            F3_BU:   data = {24'b0, shifted[7:0]};
            F3_HU:   data = {16'b0, shifted[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: validates the access, holds a single bus request
// until ack or timeout, then reports the result with a one-cycle done pulse.
//
// state   | meaning
// IDLE    | waiting for start from the core
// REQ     | bus_req held, waiting for bus_ack or timeout
// DONE    | one-cycle completion, results updated
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mem_write,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] ALU_result,
    input  logic [DATA_WIDTH-1:0] data_rs2,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  misaligned,
    output logic                  bus_error,
    load_store_unit_if.master     bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [1:0]              off_q;
    logic [2:0]              f3_q;
    logic                    we_q;
    logic                    done_q;
    logic                    mis_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   ld_q;
    logic                    req_q;
    logic                    bwe_q;
    logic [DATA_WIDTH-1:0]   addr_q;
    logic [3:0]              be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   aligned;

    lsu_load_align u_align (
        .rdata  (bus.bus_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .data   (aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= '0;
            req_q   <= 1'b0;
            bwe_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_illegal(funct3, ALU_result[1:0], mem_write)) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            mis_q  <= 1'b1;
                            err_q  <= 1'b0;
                        end else begin
                            state   <= ST_REQ;
                            cnt     <= '0;
                            off_q   <= ALU_result[1:0];
                            f3_q    <= funct3;
                            we_q    <= mem_write;
                            req_q   <= 1'b1;
                            bwe_q   <= mem_write;
                            addr_q  <= {ALU_result[DATA_WIDTH-1:2], 2'b00};
                            be_q    <= byte_enable(funct3, ALU_result[1:0]);
                            wdata_q <= mem_write ? wdata_lane(funct3, ALU_result[1:0], data_rs2) : '0;
                        end
                    end
                end
                ST_REQ: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (bus.bus_ack || cnt == CNT_LAST) begin
                        state   <= ST_DONE;
                        done_q  <= 1'b1;
                        mis_q   <= 1'b0;
                        err_q   <= !bus.bus_ack;
                        req_q   <= 1'b0;
                        bwe_q   <= 1'b0;
                        addr_q  <= '0;
                        be_q    <= '0;
                        wdata_q <= '0;
                        if (!bus.bus_ack) begin
                            ld_q <= '0;
                        end else if (!we_q) begin
                            ld_q <= aligned;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign stall      = (state == ST_IDLE && start) || state == ST_REQ;
    assign done       = done_q;
    assign load_data  = ld_q;
    assign misaligned = mis_q;
    assign bus_error  = err_q;

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = bwe_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the address/data width; only 32 is supported.
REQ-002 Parameter TIMEOUT_CYCLES, default 15, SHALL set the maximum REQ-state cycles awaiting bus_ack.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  core requests a memory access this cycle (load/store instruction in execute).
REQ-006 mem_write  input  1  1 = store, 0 = load; sampled with start.
REQ-007 funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 ALU_result  input  32  effective byte address from the ALU (rs1 + imm).
REQ-009 data_rs2  input  32  store data.
REQ-010 stall  output  1  holds the PC/pipeline while an access is in flight.
REQ-011 done  output  1  one-cycle pulse; access finished; load_data/flags valid.
REQ-012 load_data  output  32  lane-extracted, sign- or zero-extended load result.
REQ-013 misaligned  output  1  valid with done; access rejected for alignment or illegal funct3.
REQ-014 bus_error  output  1  valid with done; access abandoned on timeout.
REQ-015 bus_req, bus_we  output  1 each  memory request and write enable.
REQ-016 bus_addr  output  32  word-aligned address {addr[31:2],2'b00}.
REQ-017 bus_be  output  4  byte enables; bus_wdata  output  32  lane-positioned store data.
REQ-018 bus_ack  input  1; bus_rdata  input  32  memory completion and read word.

Function
REQ-019 FSM states IDLE, REQ, DONE SHALL be the only states.
REQ-020 IDLE + start: legal access -> latch address, width, mem_write, store data; go to REQ.
REQ-021 IDLE + start, illegal: H/HU with addr[0]=1, W with addr[1:0]!=0, funct3 in {011,110,111}, or store with funct3[2]=1 -> go to DONE with misaligned=1; no bus_req issued.
REQ-022 stall SHALL equal (state==IDLE && start) || state==REQ; stall is low in DONE.
REQ-023 In REQ, bus_req=1 and bus_addr/bus_we/bus_be/bus_wdata SHALL remain stable until ack or timeout.
REQ-024 bus_be: B = 4'b0001<<addr[1:0]; H = 4'b0011<<addr[1:0]; W = 4'b1111; loads drive the same pattern.
REQ-025 bus_wdata: data_rs2 byte/half shifted left by 8*addr[1:0]; unused lanes 0.
REQ-026 bus_ack is sampled only in REQ; ack in IDLE/DONE SHALL be ignored.
REQ-027 REQ + bus_ack: for loads, capture lane of bus_rdata at offset addr[1:0], extend per funct3 (B/H sign, BU/HU zero, W none); go to DONE.
REQ-028 Counter SHALL clear on REQ entry and increment per REQ cycle without ack; at TIMEOUT_CYCLES without ack go to DONE with bus_error=1, load_data=0.
REQ-029 Ack and timeout in the same cycle: ack wins, bus_error=0.
REQ-030 DONE lasts exactly one cycle: done=1, then IDLE; start in DONE is ignored (core re-presents it).
REQ-031 Minimum latency: start cycle 0, ack cycle 1, done cycle 2.
REQ-032 load_data, misaligned, bus_error SHALL hold their values until the next DONE; stores leave load_data unchanged.

Reset
REQ-033 rst=1 at a clock edge SHALL force IDLE, clear the counter, and drive stall=0 (with start=0), done=0, load_data=0, misaligned=0, bus_error=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
REQ-034 Reset mid-REQ SHALL abandon the access; bus_req is low from the next cycle; no done pulse.

Structure
REQ-035 Package lsu_pkg SHALL hold the funct3 width codes, the state enum, and the TIMEOUT_CYCLES default.
REQ-036 Sub-module lsu_load_align (combinational lane extract + extend) SHALL be instantiated once.

Verification
REQ-037 LB at addr 0x103, rdata 0x80FF_1234, ack after 2 cycles -> bus_addr 0x100, bus_be 1000, load_data 0xFFFF_FF80, done at cycle 3.
REQ-038 SH at 0x202, rs2 0xDEAD_BEEF -> bus_we=1, bus_be 1100, bus_wdata 0xBEEF_0000; done one cycle after ack.
REQ-039 LW at 0x301 -> no bus_req, done+misaligned at cycle 1, stall high at cycle 0 only.
REQ-040 LHU at 0x000 with ack never asserted -> bus_error+done after 15 REQ cycles, load_data 0.
REQ-041 rst asserted in second REQ cycle, ack the following cycle -> IDLE, no done, all outputs 0.
